// File: rtl/priority_encoder_seq_pkg.sv
// Shared sizing and encode/decode helpers for the sequential priority encoder
// and the matching downstream decoder.
package priority_encoder_seq_pkg;

    localparam int PE_N   = 4;
    localparam int CODE_W = $clog2(PE_N);

    // Highest set bit wins; an all-zero vector maps to 0.
    function automatic logic [CODE_W-1:0] hi_index(input logic [PE_N-1:0] v);
        hi_index = '0;
        for (int i = 0; i < PE_N; i++) begin
            if (v[i]) hi_index = CODE_W'(i);
        end
    endfunction

    function automatic logic [PE_N-1:0] onehot(input logic [CODE_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/priority_encoder_seq_if.sv
// Request/code handshake bundle between a request source/consumer (master)
// and the encoder (slave).
interface priority_encoder_seq_if
    import priority_encoder_seq_pkg::*;
#(
    parameter int N = PE_N,
    parameter int W = CODE_W
);
    logic         enable;
    logic [N-1:0] req;
    logic [W-1:0] code;
    logic         valid;
    logic         ready;
    logic [N-1:0] pending;
    logic         overrun;

    modport master (
        output enable, req, ready,
        input  code, valid, pending, overrun
    );

    modport slave (
        input  enable, req, ready,
        output code, valid, pending, overrun
    );
endinterface

// File: rtl/priority_encoder_seq_prio_pick.sv
// Combinational highest-set-bit picker: index of the top pending line and its
// one-hot grant, the grant gated by the load enable.
module priority_encoder_seq_prio_pick
    import priority_encoder_seq_pkg::*;
(
    input  logic [PE_N-1:0]   i_vec,
    input  logic              i_en,
    output logic [PE_N-1:0]   o_gnt,
    output logic [CODE_W-1:0] o_idx
);
    assign o_idx = hi_index(i_vec);
    assign o_gnt = i_en ? onehot(o_idx) : '0;
endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential N-to-log2(N) encoder: captures request lines into a pending set
// and issues their indices highest-first over a valid/ready handshake.
module priority_encoder_seq
    import priority_encoder_seq_pkg::*;
#(
    parameter int N = PE_N,
    parameter int W = CODE_W
)(
    input logic                    clk,
    input logic                    rst,
    priority_encoder_seq_if.slave  bus
);
    if (N != PE_N || N < 2 || (N & (N - 1)) != 0 || W != $clog2(N)) begin : g_bad_size
        $error("priority_encoder_seq: N must be a power of two >= 2 matching the package, W = log2(N)");
    end

    logic [N-1:0] r_pending;
    logic [W-1:0] r_code;
    logic         r_valid;
    logic         r_overrun;

    logic [N-1:0] w_cap;
    logic [N-1:0] w_gnt;
    logic [W-1:0] w_idx;
    logic         w_load;

    assign w_cap  = bus.req & {N{bus.enable}};
    // Refill the output slot whenever it is empty or being consumed this edge.
    assign w_load = (~r_valid | bus.ready) & (|r_pending);

    priority_encoder_seq_prio_pick u_pick (
        .i_vec (r_pending),
        .i_en  (w_load),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Capture is OR'd after clearing the grant, so a same-cycle
            // re-request of the granted line is kept for a later issue.
            r_pending <= (r_pending & ~w_gnt) | w_cap;
            r_overrun <= |(w_cap & r_pending & ~w_gnt);
            if (w_load) begin
                r_code  <= w_idx;
                r_valid <= 1'b1;
            end else if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.code    = r_code;
    assign bus.valid   = r_valid;
    assign bus.pending = r_pending;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed and randomized checks of priority_encoder_seq against a set-based
// reference model of pending events and the output slot.
module tb_priority_encoder_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priority_encoder_seq_if #(.N(4), .W(2)) bus ();

    priority_encoder_seq #(.N(4), .W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: a set of pending line numbers plus the presented slot.
    bit m_set [4];
    bit m_valid;
    int m_code;
    bit m_ovr;
    int code3_issues;

    function automatic int top_of_set();
        int best = -1;
        for (int i = 0; i < 4; i++) if (m_set[i] && i > best) best = i;
        return best;
    endfunction

    function automatic logic [3:0] set_bits();
        logic [3:0] b = '0;
        for (int i = 0; i < 4; i++) b[i] = m_set[i];
        return b;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  top;
        bit  slot_free;
        bit  taken [4];
        logic [3:0] cap;
        cap = bus.enable ? bus.req : 4'b0;
        if (rst) begin
            foreach (m_set[i]) m_set[i] = 1'b0;
            m_valid = 1'b0;
            m_code  = 0;
            m_ovr   = 1'b0;
            return;
        end
        top       = top_of_set();
        slot_free = !m_valid || bus.ready;
        foreach (taken[i]) taken[i] = 1'b0;
        if (m_valid && bus.ready) m_valid = 1'b0;
        if (slot_free && top >= 0) begin
            taken[top] = 1'b1;
            m_code     = top;
            m_valid    = 1'b1;
        end
        m_ovr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cap[i] && m_set[i] && !taken[i]) m_ovr = 1'b1;
            if (taken[i]) m_set[i] = 1'b0;
            if (cap[i])   m_set[i] = 1'b1;
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".valid"},   int'(bus.valid),   int'(m_valid));
        chk({tag, ".code"},    int'(bus.code),    m_code);
        chk({tag, ".pending"}, int'(bus.pending), int'(set_bits()));
        chk({tag, ".overrun"}, int'(bus.overrun), int'(m_ovr));
        if (bus.valid && bus.code == 2'd3 && bus.ready) code3_issues++;
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.req    = 4'b1111;
        bus.ready  = 1'b1;
        m_valid = 0; m_code = 0; m_ovr = 0;
        foreach (m_set[i]) m_set[i] = 1'b0;

        // Reset with all lines requesting
        rst = 1'b1;
        tick("rst0");
        tick("rst1");
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_valid",   int'(bus.valid),   0);
        chk("rst_code",    int'(bus.code),    0);
        chk("rst_overrun", int'(bus.overrun), 0);
        rst = 1'b0;
        bus.req = 4'b0000;

        // Single request: two cycles to valid
        bus.req = 4'b0100; tick("single_cap");
        chk("single_not_yet", int'(bus.valid), 0);
        bus.req = 4'b0000; tick("single_issue");
        chk("single_valid", int'(bus.valid), 1);
        chk("single_code",  int'(bus.code),  2);
        tick("single_done");
        chk("single_empty_valid", int'(bus.valid),   0);
        chk("single_empty_pend",  int'(bus.pending), 0);

        // Priority drain 3,1,0 back-to-back
        bus.req = 4'b1011; tick("drain_cap");
        bus.req = 4'b0000;
        tick("drain_a"); chk("drain_code3", int'(bus.code), 3);
        tick("drain_b"); chk("drain_code1", int'(bus.code), 1);
        tick("drain_c"); chk("drain_code0", int'(bus.code), 0);
        chk("drain_c_valid", int'(bus.valid), 1);
        tick("drain_end"); chk("drain_end_valid", int'(bus.valid), 0);
        chk("drain_hold_code", int'(bus.code), 0);

        // Stall with ready low
        bus.ready = 1'b0;
        bus.req = 4'b0011; tick("stall_cap");
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) tick("stall_hold");
        chk("stall_valid", int'(bus.valid),   1);
        chk("stall_code",  int'(bus.code),    1);
        chk("stall_pend",  int'(bus.pending), 1);
        bus.ready = 1'b1;
        tick("stall_acc");
        chk("stall_next_code", int'(bus.code), 0);
        tick("stall_end");

        // Overrun merge, then enable gating
        bus.ready = 1'b0;
        bus.req = 4'b0011; tick("ovr_cap");
        bus.req = 4'b0000; tick("ovr_stall");
        bus.req = 4'b0001; tick("ovr_hit");
        chk("ovr_pulse", int'(bus.overrun), 1);
        chk("ovr_pend",  int'(bus.pending), 1);
        bus.req = 4'b0000; tick("ovr_clear");
        chk("ovr_one_cycle", int'(bus.overrun), 0);
        bus.enable = 1'b0; bus.req = 4'b1000; tick("en_off");
        chk("en_off_pend", int'(bus.pending), 1);
        chk("en_off_ovr",  int'(bus.overrun), 0);
        bus.enable = 1'b1; bus.req = 4'b0000; bus.ready = 1'b1;
        tick("ovr_drain0"); tick("ovr_drain1"); tick("ovr_drain2");

        // Re-request of line 3 on the cycle it is granted
        code3_issues = 0;
        bus.req = 4'b1000; tick("col_cap");
        bus.req = 4'b1000; tick("col_regrant");
        bus.req = 4'b0000; tick("col_again");
        tick("col_end");
        chk("col_code3_twice", code3_issues, 2);

        // Reset while a code is presented
        bus.ready = 1'b0;
        bus.req = 4'b0110; tick("mid_cap");
        bus.req = 4'b0000; tick("mid_valid");
        chk("mid_pre_valid", int'(bus.valid), 1);
        rst = 1'b1; tick("mid_rst");
        chk("mid_rst_valid", int'(bus.valid),   0);
        chk("mid_rst_pend",  int'(bus.pending), 0);
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus.req    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            bus.enable = ($urandom_range(0, 7) != 0);
            bus.ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 63) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
Name: priority_encoder_seq

Overview:
- Sequential 4-to-2 encoder with request capture. It is the inverse of the team's 2-to-4 enable decoder.
- Each input line raises a request. The block latches requests into a pending register and presents them one at a time as a 2-bit code with a valid/ready handshake.
- The highest index wins. Used as an event/interrupt encoder feeding a downstream consumer that later re-decodes the code.

Parameters:
- N, 4, number of request lines (power of two, minimum 2).
- W, 2, code width. Must equal log2(N); checked by assertion.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when low, new requests are ignored (not captured). Pending requests still drain.
- req  input  N  per-line request pulses or levels. Sampled every cycle.
- code  output  W  encoded index of the presented request.
- valid  output  1  code is valid.
- ready  input  1  consumer accepts code when valid and ready are both high at a clk edge.
- pending  output  N  current pending register (for debug/status).
- overrun  output  1  one-cycle pulse: a captured request hit a line that was already pending.

Behaviour:
- One clock (clk). Synchronous, active-high reset (rst). All state updates on the rising edge of clk.
- Reset: pending=0, valid=0, code=0, overrun=0. Reset has priority over everything. Asserting rst mid-transfer drops the presented code and all pending requests with no handshake completion.
- Capture: cap = req & {N{enable}}.
- Load condition: load = (~valid | ready) & (|pending).
- Grant: gnt = one-hot of the highest set bit of pending, evaluated only when load is high; otherwise gnt=0.
- Pending update: pending_next = (pending & ~gnt) | cap. A new capture on the line being granted in the same cycle re-sets that bit, so the event is serviced again later and never lost.
- Output register:
  - On load: code <= index(gnt), valid <= 1.
  - Else if valid & ready: valid <= 0, code holds its last value.
  - Else: hold.
- Back-to-back: with ready held high and several lines pending, one code is issued per cycle, in descending index order. There are no bubbles between codes.
- Latency: req captured at edge t appears in pending after edge t. With an empty output and no higher-priority pending line, valid rises after edge t+1, i.e. 2 cycles from request to valid.
- Handshake rules:
  - While valid=1 and ready=0, code and valid hold stable.
  - pending may still accumulate while stalled.
  - valid never drops without a ready acceptance (except on rst).
- Overrun: overrun_next = |(cap & pending & ~gnt). It pulses one cycle. No state is lost; the request merges into the already-pending bit.
- Priority starvation: a continuously re-requested high line can starve lower lines. This is accepted; no fairness is provided.
- Empty: pending=0 and output consumed → valid=0, code holds its last value.
- Width rules:
  - index(gnt) is an unsigned W-bit value.
  - When no bit is set, the encoder function returns 0. This value is never used because load requires |pending.

Decomposition:
- Shared package contains:
  - the localparam CODE_W = $clog2(N) check;
  - a function hi_index(N-bit) returning the W-bit highest set index;
  - a function onehot(W-bit) returning the N-bit decode (also reused by the decoder side).
- One sub-module: prio_pick, the combinational highest-set-bit picker producing gnt and an index. It is instantiated once; the top holds pending, the output register and overrun.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 → after release pending=0, valid=0, code=0, overrun=0.
- Single request: req=4'b0100 for 1 cycle, ready=1 → valid=1, code=2 exactly 2 cycles later, then valid=0 and pending=0 the next cycle.
- Priority drain: req=4'b1011 in one cycle, ready=1 → codes 3,1,0 on 3 consecutive cycles, then valid=0.
- Stall: req=4'b0011, ready=0 for 5 cycles → valid=1, code=1 held stable and pending=4'b0001. Raise ready → code 1 accepted, then code 0 the next cycle.
- Overrun and merge: stall with pending=4'b0001, pulse req=4'b0001 → overrun=1 for one cycle, pending stays 4'b0001. With enable=0, pulse req=4'b1000 → pending unchanged, no overrun.
- Grant/re-request collision and reset mid-operation:
  - req[3] pulses in the same cycle line 3 is granted → code 3 is issued twice in total.
  - Assert rst while valid=1 → next cycle valid=0, pending=0.
